// File: rtl/dmem_pkg.sv
// dmem_pkg: store width codes and sequencer state encoding shared by the dmem store path
package dmem_pkg;
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;
    typedef enum logic {ST_IDLE, ST_SPLIT} state_t;
endpackage

// File: rtl/dmem_beat_gen.sv
// dmem_beat_gen: byte enables and lane-shifted data for the one or two write beats of a store
module dmem_beat_gen (
    input  logic [2:0]  func3,
    input  logic [2:0]  off,
    input  logic [63:0] data,
    output logic [7:0]  be0,
    output logic [63:0] wd0,
    output logic [7:0]  be1,
    output logic [63:0] wd1,
    output logic        split,
    output logic        illegal
);
    logic [3:0]  nb;
    logic [15:0] lanes;
    always_comb begin
        nb = 4'd1 << func3[1:0];
        // byte mask over two doublewords; the upper half is whatever spills past byte 7
        lanes = ((16'd1 << nb) - 16'd1) << off;
        illegal = func3[2];
        be0 = lanes[7:0];
        be1 = lanes[15:8];
        split = !illegal && (be1 != 8'h00);
        wd0 = data << {off, 3'b000};
        wd1 = data >> (7'd64 - {1'b0, off, 3'b000});
    end
endmodule

// File: rtl/dmem_store_sequencer.sv
// dmem_store_sequencer: issues MEM-stage stores onto the 64-bit byte-enabled dmem port, splitting misaligned ones
module dmem_store_sequencer
    import dmem_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_func3,
    input  logic [63:0]      req_addr,
    input  logic [63:0]      req_data,
    output logic [7:0]       mem_we,
    output logic [63:0]      mem_wdata,
    output logic [IDX_W-1:0] mem_addr,
    output logic             st_err
);
    state_t           state, nxt;
    logic [7:0]       be0, be1, be1_q;
    logic [63:0]      wd0, wd1, wd1_q;
    logic [IDX_W-1:0] idx, idx1_q;
    logic             split, illegal, hs;
    logic             unused_addr;

    assign idx = req_addr[IDX_W+2:3];
    assign unused_addr = ^req_addr[63:IDX_W+3];

    dmem_beat_gen u_beat (
        .func3  (req_func3),
        .off    (req_addr[2:0]),
        .data   (req_data),
        .be0    (be0),
        .wd0    (wd0),
        .be1    (be1),
        .wd1    (wd1),
        .split  (split),
        .illegal(illegal)
    );

    always_comb begin
        req_ready = state == ST_IDLE;
        hs = req_valid && req_ready;
        nxt = (hs && split) ? ST_SPLIT : ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            mem_we <= 8'h00;
            mem_wdata <= 64'd0;
            mem_addr <= '0;
            st_err <= 1'b0;
            be1_q <= 8'h00;
            wd1_q <= 64'd0;
            idx1_q <= '0;
        end else begin
            state <= nxt;
            st_err <= hs && illegal;
            if (state == ST_SPLIT) begin
                mem_we <= be1_q;
                mem_wdata <= wd1_q;
                mem_addr <= idx1_q;
            end else if (hs) begin
                mem_we <= illegal ? 8'h00 : be0;
                mem_wdata <= wd0;
                mem_addr <= idx;
            end else begin
                mem_we <= 8'h00;
            end
            // second beat targets the next doubleword, wrapping at the top of memory
            if (hs && split) begin
                be1_q <= be1;
                wd1_q <= wd1;
                idx1_q <= idx + 1'b1;
            end
        end
    end
endmodule
